// File: rtl/ftb_update_sched_pkg.sv
// ----------------------------------------------------------------------------
// ftb_update_sched_pkg
// Shared FTB definitions for the update scheduler:
//   - address/field widths and FTB geometry
//   - BPupdateInfo_t (commit training record), ftbInfo_t, ftbEntry_t
//   - helpers: counterUpdate, calcuTarStat, buildFtbInfo, ftbIdx, ftbTag
// ----------------------------------------------------------------------------
package ftb_update_sched_pkg;

   localparam int XLEN               = 32;
   localparam int FTB_SETS           = 512;
   localparam int FTB_IDX_W          = $clog2(FTB_SETS);
   localparam int FTB_TAG_W          = 16;
   localparam int FTB_FALLTHRU_WIDTH = 5;
   localparam int FTB_TARGET_WIDTH   = 12;
   localparam int TAR_HI_W           = XLEN - FTB_TARGET_WIDTH - 1;

   typedef enum logic [1:0] {
      BR_COND = 2'd0,
      BR_JAL  = 2'd1,
      BR_JALR = 2'd2,
      BR_RET  = 2'd3
   } br_type_t;

   // Where the target's upper bits sit relative to the block start.
   typedef enum logic [1:0] {
      TAR_FIT = 2'd0,
      TAR_OVF = 2'd1,
      TAR_UDF = 2'd2
   } tar_stat_t;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RD_REQ  = 2'd1,
      S_RD_WAIT = 2'd2,
      S_WR_REQ  = 2'd3
   } sched_state_t;

   typedef struct packed {
      logic [XLEN-1:0] startAddr;
      logic [XLEN-1:0] fallthruAddr;
      logic [XLEN-1:0] targetAddr;
      logic            taken;
      logic            hit_on_ftb;
      br_type_t        branch_type;
   } BPupdateInfo_t;

   typedef struct packed {
      logic                          carry;
      logic [FTB_FALLTHRU_WIDTH-1:0] fallthruAddr;
      tar_stat_t                     tarStat;
      logic [FTB_TARGET_WIDTH-1:0]   targetAddr;
      br_type_t                      branch_type;
   } ftbInfo_t;

   typedef struct packed {
      logic [FTB_TAG_W-1:0] tag;
      ftbInfo_t             info;
      logic [1:0]           ctr;
   } ftbEntry_t;

   // 2-bit saturating direction counter.
   function automatic logic [1:0] counterUpdate(input logic [1:0] ctr, input logic taken);
      logic [1:0] res;
      res = ctr;
      if (taken && ctr != 2'd3)
         res = ctr + 2'd1;
      else if (!taken && ctr != 2'd0)
         res = ctr - 2'd1;
      return res;
   endfunction

   function automatic tar_stat_t calcuTarStat(input logic [XLEN-1:0] start_addr,
                                              input logic [XLEN-1:0] target_addr);
      logic [TAR_HI_W-1:0] hi_s;
      logic [TAR_HI_W-1:0] hi_t;
      tar_stat_t           res;
      hi_s = start_addr[XLEN-1:FTB_TARGET_WIDTH+1];
      hi_t = target_addr[XLEN-1:FTB_TARGET_WIDTH+1];
      res  = TAR_FIT;
      if (hi_t > hi_s)
         res = TAR_OVF;
      else if (hi_t < hi_s)
         res = TAR_UDF;
      return res;
   endfunction

   function automatic ftbInfo_t buildFtbInfo(input BPupdateInfo_t u);
      ftbInfo_t info;
      info.carry        = u.fallthruAddr[XLEN-1:FTB_FALLTHRU_WIDTH+1] !=
                          u.startAddr[XLEN-1:FTB_FALLTHRU_WIDTH+1];
      info.fallthruAddr = u.fallthruAddr[FTB_FALLTHRU_WIDTH:1];
      info.tarStat      = calcuTarStat(u.startAddr, u.targetAddr);
      info.targetAddr   = u.targetAddr[FTB_TARGET_WIDTH:1];
      info.branch_type  = u.branch_type;
      return info;
   endfunction

   function automatic logic [FTB_IDX_W-1:0] ftbIdx(input logic [XLEN-1:0] start_addr);
      return start_addr[FTB_IDX_W:1];
   endfunction

   function automatic logic [FTB_TAG_W-1:0] ftbTag(input logic [XLEN-1:0] start_addr);
      return start_addr[FTB_IDX_W+FTB_TAG_W:FTB_IDX_W+1];
   endfunction

endpackage

// File: rtl/ftb_update_sched_queue.sv
// ----------------------------------------------------------------------------
// ftb_upd_queue
// Small synchronous FIFO holding committed update records.
//   clk, rst (async, active-low)
//   push/din   : write when push=1 (caller guarantees !full)
//   pop/dout   : dout is the current head; pop advances it (caller guarantees !empty)
//   empty/full : occupancy flags
// Pointers carry one extra wrap bit to tell full from empty.
// ----------------------------------------------------------------------------
module ftb_upd_queue #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W:0]   wr_ptr_reg;
   logic [PTR_W:0]   rd_ptr_reg;

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr_reg[PTR_W-1:0]] <= din;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (push)
            wr_ptr_reg <= wr_ptr_reg + {{PTR_W{1'b0}}, 1'b1};
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + {{PTR_W{1'b0}}, 1'b1};
      end
   end

   assign dout  = mem[rd_ptr_reg[PTR_W-1:0]];
   assign empty = (wr_ptr_reg == rd_ptr_reg);
   assign full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                  (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
endmodule

// File: rtl/ftb_update_sched.sv
// ----------------------------------------------------------------------------
// ftb_update_sched
// Buffers commit-time FTB training records and performs one read-modify-write
// of the single-port FTB SRAM per kept record, sharing the SRAM with the
// prediction lookup (prediction wins unless the scheduler has starved).
//   clk, rst (async, active-low; all outputs forced low while asserted)
//   i_upd_vld/o_upd_rdy/i_upd_info : update record handshake
//   i_pred_req/o_pred_gnt          : predictor SRAM request / grant
//   o_sram_req/we/idx/wdata        : scheduler SRAM access
//   i_sram_rdata                   : read data, one cycle after a read grant
//   o_busy                         : records pending or RMW in progress
// ----------------------------------------------------------------------------
module ftb_update_sched
   import ftb_update_sched_pkg::*;
#(
   parameter int UPD_DEPTH    = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_upd_vld,
   output logic                 o_upd_rdy,
   input  BPupdateInfo_t        i_upd_info,
   input  logic                 i_pred_req,
   output logic                 o_pred_gnt,
   output logic                 o_sram_req,
   output logic                 o_sram_we,
   output logic [FTB_IDX_W-1:0] o_sram_idx,
   output ftbEntry_t            o_sram_wdata,
   input  ftbEntry_t            i_sram_rdata,
   output logic                 o_busy
);
   localparam int              CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   sched_state_t     state_reg, state_next;
   logic [CNT_W-1:0] starve_cnt_reg;
   ftbEntry_t        wdata_reg;
   ftbEntry_t        wdata_next;

   logic [$bits(BPupdateInfo_t)-1:0] q_dout;
   BPupdateInfo_t                    head;
   logic q_push, q_pop, q_empty, q_full;
   logic sram_req, sched_grant, filtered, rd_hit;

   assign q_push = i_upd_vld & o_upd_rdy;

   ftb_upd_queue #(
      .WIDTH ($bits(BPupdateInfo_t)),
      .DEPTH (UPD_DEPTH)
   ) u_queue (
      .clk   (clk),
      .rst   (rst),
      .push  (q_push),
      .din   (i_upd_info),
      .pop   (q_pop),
      .dout  (q_dout),
      .empty (q_empty),
      .full  (q_full)
   );

   assign head     = BPupdateInfo_t'(q_dout);
   // Not-taken blocks that missed the FTB carry nothing worth training.
   assign filtered = !head.taken && !head.hit_on_ftb;

   assign sram_req    = (state_reg == S_RD_REQ) || (state_reg == S_WR_REQ);
   assign sched_grant = sram_req && (!i_pred_req || starve_cnt_reg == LIMIT);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state_reg <= S_IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      q_pop      = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (!q_empty) begin
               if (filtered)
                  q_pop = 1'b1;
               else
                  state_next = S_RD_REQ;
            end
         end
         S_RD_REQ: begin
            if (sched_grant)
               state_next = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            state_next = S_WR_REQ;
         end
         S_WR_REQ: begin
            // The record stays at the head until its write lands, so a reset
            // mid-RMW simply discards it.
            if (sched_grant) begin
               q_pop      = 1'b1;
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         starve_cnt_reg <= '0;
      else if (sched_grant)
         starve_cnt_reg <= '0;
      else if (sram_req && starve_cnt_reg != LIMIT)
         starve_cnt_reg <= starve_cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   // Merge the freshly read entry with the committed record.
   always_comb begin
      rd_hit          = (i_sram_rdata.tag == ftbTag(head.startAddr));
      wdata_next      = '0;
      wdata_next.tag  = ftbTag(head.startAddr);
      wdata_next.info = buildFtbInfo(head);
      if (rd_hit)
         wdata_next.ctr = counterUpdate(i_sram_rdata.ctr, head.taken);
      else
         wdata_next.ctr = head.taken ? 2'd2 : 2'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         wdata_reg <= '0;
      else if (state_reg == S_RD_WAIT)
         wdata_reg <= wdata_next;
   end

   assign o_sram_req   = sram_req;
   assign o_sram_we    = (state_reg == S_WR_REQ);
   assign o_sram_idx   = sram_req ? ftbIdx(head.startAddr) : '0;
   assign o_sram_wdata = (state_reg == S_WR_REQ) ? wdata_reg : '0;
   // Gated by reset so both stay low while reset is held.
   assign o_pred_gnt   = rst & i_pred_req & !sched_grant;
   assign o_upd_rdy    = rst & !q_full;
   assign o_busy       = !q_empty || (state_reg != S_IDLE);

   // Stored branch info of the old entry plays no part in the merge.
   logic unused_rdata_info;
   assign unused_rdata_info = ^i_sram_rdata.info;
endmodule

// File: tb/tb_ftb_update_sched.sv
module tb_ftb_update_sched;
   import ftb_update_sched_pkg::*;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 i_upd_vld;
   logic                 o_upd_rdy;
   BPupdateInfo_t        i_upd_info;
   logic                 i_pred_req;
   logic                 o_pred_gnt;
   logic                 o_sram_req;
   logic                 o_sram_we;
   logic [FTB_IDX_W-1:0] o_sram_idx;
   ftbEntry_t            o_sram_wdata;
   ftbEntry_t            sram_rdata;
   logic                 o_busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ftb_update_sched #(
      .UPD_DEPTH    (4),
      .STARVE_LIMIT (8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .i_upd_vld    (i_upd_vld),
      .o_upd_rdy    (o_upd_rdy),
      .i_upd_info   (i_upd_info),
      .i_pred_req   (i_pred_req),
      .o_pred_gnt   (o_pred_gnt),
      .o_sram_req   (o_sram_req),
      .o_sram_we    (o_sram_we),
      .o_sram_idx   (o_sram_idx),
      .o_sram_wdata (o_sram_wdata),
      .i_sram_rdata (sram_rdata),
      .o_busy       (o_busy)
   );

   // SRAM environment model with a log of every granted write.
   ftbEntry_t mem    [FTB_SETS];
   ftbEntry_t wr_log [16];
   int        wr_cnt = 0;
   logic      sram_gnt;
   assign sram_gnt = o_sram_req && !o_pred_gnt;

   always @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < FTB_SETS; i++)
            mem[i] <= '0;
      end else if (sram_gnt) begin
         if (o_sram_we) begin
            mem[o_sram_idx]     <= o_sram_wdata;
            wr_log[wr_cnt % 16] <= o_sram_wdata;
            wr_cnt              <= wr_cnt + 1;
         end else begin
            sram_rdata <= mem[o_sram_idx];
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic BPupdateInfo_t mk(input logic [31:0] s, input logic [31:0] f,
                                        input logic [31:0] t, input logic tk,
                                        input logic hit, input br_type_t bt);
      BPupdateInfo_t u;
      u.startAddr    = s;
      u.fallthruAddr = f;
      u.targetAddr   = t;
      u.taken        = tk;
      u.hit_on_ftb   = hit;
      u.branch_type  = bt;
      return u;
   endfunction

   // Rebuild a full target from the block start and the stored entry fields.
   function automatic logic [31:0] calc_target(input logic [31:0] s, input ftbInfo_t inf);
      logic [TAR_HI_W-1:0] hi;
      hi = s[31:FTB_TARGET_WIDTH+1];
      if (inf.tarStat == TAR_OVF)
         hi = hi + 1'b1;
      else if (inf.tarStat == TAR_UDF)
         hi = hi - 1'b1;
      return {hi, inf.targetAddr, 1'b0};
   endfunction

   task automatic cyc();
      @(negedge clk);
   endtask

   // Called at a negedge; returns at the negedge after the push edge.
   task automatic push_rec(input BPupdateInfo_t u);
      int n;
      i_upd_info = u;
      i_upd_vld  = 1'b1;
      n = 0;
      while (!o_upd_rdy && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("push_rdy", o_upd_rdy, 1'b1);
      $display("push start=%08h tgt=%08h taken=%0d hit=%0d", u.startAddr, u.targetAddr,
               u.taken, u.hit_on_ftb);
      @(negedge clk);
      i_upd_vld = 1'b0;
   endtask

   task automatic wait_idle(input int limit);
      int n;
      n = 0;
      while (o_busy && n < limit) begin
         @(negedge clk);
         n++;
      end
      check("idle_timeout", o_busy, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int        base;
      int        found;
      int        seen;
      ftbEntry_t e;

      rst        = 1'b0;
      i_upd_vld  = 1'b0;
      i_upd_info = '0;
      i_pred_req = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_rdy",  o_upd_rdy,  1'b0);
      check("rst_pgnt", o_pred_gnt, 1'b0);
      check("rst_busy", o_busy,     1'b0);
      check("rst_req",  o_sram_req, 1'b0);
      rst        = 1'b1;
      i_pred_req = 1'b0;
      cyc();
      check("post_rst_rdy",  o_upd_rdy, 1'b1);
      check("post_rst_busy", o_busy,    1'b0);

      // Single update, SRAM tag miss: read cycle 1, write cycle 3, idle cycle 4.
      push_rec(mk(32'h8000_1000, 32'h8000_1020, 32'h8000_1100, 1'b1, 1'b0, BR_COND));
      check("t1_c0_req",  o_sram_req, 1'b0);
      check("t1_c0_busy", o_busy,     1'b1);
      cyc();
      check("t1_c1_req", o_sram_req, 1'b1);
      check("t1_c1_we",  o_sram_we,  1'b0);
      check("t1_c1_idx", o_sram_idx, 9'h000);
      cyc();
      check("t1_c2_req", o_sram_req, 1'b0);
      cyc();
      check("t1_c3_req", o_sram_req,               1'b1);
      check("t1_c3_we",  o_sram_we,                1'b1);
      check("t1_c3_tag", o_sram_wdata.tag,         16'h0004);
      check("t1_c3_ctr", o_sram_wdata.ctr,         2'd2);
      check("t1_c3_ts",  o_sram_wdata.info.tarStat, TAR_FIT);
      check("t1_c3_tgt", o_sram_wdata.info.targetAddr, 12'h880);
      check("t1_c3_ft",  o_sram_wdata.info.fallthruAddr, 5'h10);
      cyc();
      check("t1_c4_busy", o_busy, 1'b0);
      check("t1_wrcnt",   wr_cnt, 1);

      // Anti-starvation with the predictor asking every cycle.
      i_pred_req = 1'b1;
      push_rec(mk(32'h8000_1100, 32'h8000_1120, 32'h8000_1180, 1'b1, 1'b0, BR_JAL));
      check("st_idle_req",  o_sram_req, 1'b0);
      check("st_idle_pgnt", o_pred_gnt, 1'b1);
      cyc();
      for (int k = 0; k <= 8; k++) begin
         check($sformatf("st_rd_req%0d", k),  o_sram_req, 1'b1);
         check($sformatf("st_rd_pgnt%0d", k), o_pred_gnt, (k < 8));
         cyc();
      end
      check("st_wait_req",  o_sram_req, 1'b0);
      check("st_wait_pgnt", o_pred_gnt, 1'b1);
      cyc();
      for (int k = 0; k <= 8; k++) begin
         check($sformatf("st_wr_we%0d", k),   o_sram_we,  1'b1);
         check($sformatf("st_wr_pgnt%0d", k), o_pred_gnt, (k < 8));
         cyc();
      end
      check("st_done_busy", o_busy, 1'b0);
      i_pred_req = 1'b0;

      // Filtered record: popped in one cycle, no SRAM access.
      base = wr_cnt;
      push_rec(mk(32'h8000_1200, 32'h8000_1220, 32'h8000_1300, 1'b0, 1'b0, BR_COND));
      check("flt_c0_req",  o_sram_req, 1'b0);
      check("flt_c0_busy", o_busy,     1'b1);
      cyc();
      check("flt_c1_req",  o_sram_req, 1'b0);
      check("flt_c1_busy", o_busy,     1'b0);
      check("flt_wrcnt",   wr_cnt - base, 0);

      // Three back-to-back taken updates to one idx: miss, then hit, then saturate.
      base = wr_cnt;
      for (int k = 0; k < 3; k++)
         push_rec(mk(32'h8000_2000, 32'h8000_2020, 32'h8000_2100, 1'b1, 1'b1, BR_COND));
      wait_idle(100);
      check("same_wrcnt", wr_cnt - base, 3);
      for (int k = 0; k < 3; k++) begin
         e = wr_log[(base + k) % 16];
         check($sformatf("same_tag%0d", k), e.tag, 16'h0008);
         check($sformatf("same_ctr%0d", k), e.ctr, (k == 0) ? 2'd2 : 2'd3);
      end

      // Target crossing the stored-width boundary upward and downward.
      base = wr_cnt;
      push_rec(mk(32'h8000_1000, 32'h8000_1020, 32'h8000_2004, 1'b1, 1'b0, BR_JALR));
      wait_idle(100);
      push_rec(mk(32'h8000_2010, 32'h8000_2050, 32'h8000_1ff0, 1'b1, 1'b0, BR_RET));
      wait_idle(100);
      e = wr_log[base % 16];
      check("ovf_ts",    e.info.tarStat,      TAR_OVF);
      check("ovf_tgt",   e.info.targetAddr,   12'h002);
      check("ovf_carry", e.info.carry,        1'b0);
      check("ovf_ft",    e.info.fallthruAddr, 5'h10);
      check("ovf_bt",    e.info.branch_type,  BR_JALR);
      check("ovf_rt",    calc_target(32'h8000_1000, e.info), 32'h8000_2004);
      e = wr_log[(base + 1) % 16];
      check("udf_ts",    e.info.tarStat,      TAR_UDF);
      check("udf_tgt",   e.info.targetAddr,   12'hff8);
      check("udf_carry", e.info.carry,        1'b1);
      check("udf_ft",    e.info.fallthruAddr, 5'h08);
      check("udf_bt",    e.info.branch_type,  BR_RET);
      check("udf_rt",    calc_target(32'h8000_2010, e.info), 32'h8000_1ff0);

      // Fill the FIFO while the scheduler is starved; rdy returns after the first pop.
      base       = wr_cnt;
      i_pred_req = 1'b1;
      for (int k = 0; k < 4; k++)
         push_rec(mk(32'h8000_3000 + 32'(k * 64), 32'h8000_3020, 32'h8000_3100,
                     1'b1, 1'b0, BR_COND));
      check("full_rdy", o_upd_rdy, 1'b0);
      i_upd_info = mk(32'h8000_3400, 32'h8000_3420, 32'h8000_3500, 1'b1, 1'b0, BR_COND);
      i_upd_vld  = 1'b1;
      found = 0;
      for (int n = 0; n < 100 && found == 0; n++) begin
         if (o_sram_req && o_sram_we && !o_pred_gnt)
            found = 1;
         else
            cyc();
      end
      check("full_wrgnt_seen", found,     1);
      check("full_rdy_at_gnt", o_upd_rdy, 1'b0);
      cyc();
      check("full_rdy_after",  o_upd_rdy, 1'b1);
      $display("push start=%08h (5th, accepted after pop)", i_upd_info.startAddr);
      cyc();
      i_upd_vld  = 1'b0;
      i_pred_req = 1'b0;
      wait_idle(200);
      check("full_wrcnt", wr_cnt - base, 5);

      // Reset during RD_WAIT: outputs drop at once and the write is lost.
      base = wr_cnt;
      push_rec(mk(32'h8000_1234, 32'h8000_1254, 32'h8000_1300, 1'b1, 1'b0, BR_COND));
      cyc();
      check("rr_c1_req", o_sram_req, 1'b1);
      check("rr_c1_idx", o_sram_idx, 9'h11A);
      cyc();
      check("rr_c2_req",  o_sram_req, 1'b0);
      check("rr_c2_busy", o_busy,     1'b1);
      i_pred_req = 1'b1;
      #2;
      rst = 1'b0;
      #1;
      check("rr_req",  o_sram_req, 1'b0);
      check("rr_pgnt", o_pred_gnt, 1'b0);
      check("rr_rdy",  o_upd_rdy,  1'b0);
      check("rr_busy", o_busy,     1'b0);
      check("rr_we",   o_sram_we,  1'b0);
      @(negedge clk);
      rst        = 1'b1;
      i_pred_req = 1'b0;
      #1;
      check("rr_rel_busy", o_busy,    1'b0);
      check("rr_rel_rdy",  o_upd_rdy, 1'b1);
      seen = 0;
      repeat (12) begin
         cyc();
         if (o_sram_req)
            seen = 1;
      end
      check("rr_no_access", seen, 0);
      check("rr_wrcnt", wr_cnt - base, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
